mips_multicycle_ctrl: RTL and testbench

- Sequencing controller for a multicycle MIPS datapath that shares one memory for instructions and data.
- Decodes opcode and funct once per instruction and walks a Moore FSM through the fetch, decode, execute, memory and writeback steps.
- Drives all mux selects, register enables and the ALU control code.
- Holds the sequence on a memory-ready handshake, so variable-latency memory is supported.

---
 rtl/mips_multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: Moore FSM driving datapath selects,
// register enables and ALU control, stalling on a memory-ready handshake.
module mips_multicycle_ctrl #(
  parameter bit USE_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_ready;
  logic       w_bad_op;
  logic [1:0] w_aluop;
  logic       w_pcen;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;

  assign w_ready = USE_READY ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_bad_op)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_bad_op = 1'b0;
    w_next   = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next   = S_FETCH;
            w_bad_op = 1'b1;
          end
        endcase
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pcen     = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    w_aluop    = 2'b00;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_pcen    = w_ready;
        w_irwrite = w_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        w_aluop = 2'b01;
        pcsrc   = 2'b01;
        w_pcen  = zero;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        pcsrc  = 2'b10;
        w_pcen = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (w_aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Write strobes are forced low combinationally so an asserted reset
  // cannot leak a side effect in the cycle it arrives.
  assign pcen       = w_pcen & reset;
  assign irwrite    = w_irwrite & reset;
  assign memwrite   = w_memwrite & reset;
  assign regwrite   = w_regwrite & reset;
  assign state      = r_state;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected output
// vectors are queued by the driver and checked by an independent monitor.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       illegal_op;

  mips_multicycle_ctrl #(.USE_READY(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  logic [19:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          done = 1'b0;

  // Field order: state, pcen, iord, memwrite, irwrite, regdst, memtoreg,
  // regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal_op.
  function automatic logic [19:0] ev(int st, int pe, int io, int mw, int iw,
                                     int rd, int mt, int rw, int sa, int sb,
                                     int ps, int ac, int il);
    logic [3:0] s4;
    logic [1:0] b2, p2;
    logic [2:0] a3;
    s4 = st[3:0];
    b2 = sb[1:0];
    p2 = ps[1:0];
    a3 = ac[2:0];
    return {s4, pe[0], io[0], mw[0], iw[0], rd[0], mt[0], rw[0], sa[0],
            b2, p2, a3, il[0]};
  endfunction

  task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic mr, input logic [19:0] e,
                      input string nm);
    @(posedge clk);
    #1;
    reset     = rst;
    op        = o;
    funct     = f;
    zero      = z;
    mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    logic [19:0] act, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %b want %b (st,pe,io,mw,iw,rd,mt,rw,sa,sb,ps,ac,il)",
                   nm, act, e);
        end
      end
    end
  end

  initial begin : driver
    // reset held low with mem_ready=1
    for (int i = 0; i < 3; i++)
      step(0, LW, 0, 0, 1, ev(0,0,0,0,0,0,0,0,0,1,0,2,0), "reset_hold");
    // lw, ready every cycle: 0,1,2,3,4,0
    step(1, LW, 0, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "lw_fetch");
    step(1, LW, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,0), "lw_decode");
    step(1, LW, 0, 0, 1, ev(2,0,0,0,0,0,0,0,1,2,0,2,0), "lw_memadr");
    step(1, LW, 0, 0, 1, ev(3,0,1,0,0,0,0,0,0,0,0,2,0), "lw_memrd");
    step(1, LW, 0, 0, 1, ev(4,0,0,0,0,0,1,1,0,0,0,2,0), "lw_memwb");
    // sw with three wait cycles in MEMWR
    step(1, SW, 0, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "sw_fetch");
    step(1, SW, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,3,0,2,0), "sw_decode_ready_ignored");
    step(1, SW, 0, 0, 1, ev(2,0,0,0,0,0,0,0,1,2,0,2,0), "sw_memadr");
    for (int i = 0; i < 3; i++)
      step(1, SW, 0, 0, 0, ev(5,0,1,1,0,0,0,0,0,0,0,2,0), "sw_memwr_wait");
    step(1, SW, 0, 0, 1, ev(5,0,1,1,0,0,0,0,0,0,0,2,0), "sw_memwr_commit");
    // FETCH with one memory stall, then R-type slt
    step(1, RT, 6'b101010, 0, 0, ev(0,0,0,0,0,0,0,0,0,1,0,2,0), "fetch_stall");
    step(1, RT, 6'b101010, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "rt_fetch");
    step(1, RT, 6'b101010, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,0), "rt_decode");
    step(1, RT, 6'b101010, 0, 1, ev(6,0,0,0,0,0,0,0,1,0,0,7,0), "rt_exec_slt");
    step(1, RT, 6'b101010, 0, 1, ev(7,0,0,0,0,1,0,1,0,0,0,2,0), "rt_aluwb");
    // R-type and, or, unknown funct
    step(1, RT, 6'b100100, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "and_fetch");
    step(1, RT, 6'b100100, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,0), "and_decode");
    step(1, RT, 6'b100101, 0, 1, ev(6,0,0,0,0,0,0,0,1,0,0,1,0), "exec_or");
    step(1, RT, 6'b111000, 0, 1, ev(7,0,0,0,0,1,0,1,0,0,0,2,0), "aluwb2");
    step(1, RT, 6'b111000, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "unk_fetch");
    step(1, RT, 6'b111000, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,0), "unk_decode");
    step(1, RT, 6'b100010, 0, 1, ev(6,0,0,0,0,0,0,0,1,0,0,6,0), "exec_sub");
    step(1, RT, 6'b111000, 0, 1, ev(7,0,0,0,0,1,0,1,0,0,0,2,0), "aluwb3");
    // beq taken / not taken
    step(1, BEQ, 0, 1, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "beq_fetch");
    step(1, BEQ, 0, 1, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,0), "beq_decode");
    step(1, BEQ, 0, 1, 1, ev(8,1,0,0,0,0,0,0,1,0,1,6,0), "beq_taken");
    step(1, BEQ, 0, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "beq2_fetch");
    step(1, BEQ, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,0), "beq2_decode");
    step(1, BEQ, 0, 0, 1, ev(8,0,0,0,0,0,0,0,1,0,1,6,0), "beq_not_taken");
    // jump
    step(1, J, 0, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "j_fetch");
    step(1, J, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,0), "j_decode");
    step(1, J, 0, 0, 1, ev(11,1,0,0,0,0,0,0,0,0,2,2,0), "j_jump");
    // lw with one stall in MEMRD
    step(1, LW, 0, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "lw2_fetch");
    step(1, LW, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,0), "lw2_decode");
    step(1, LW, 0, 0, 1, ev(2,0,0,0,0,0,0,0,1,2,0,2,0), "lw2_memadr");
    step(1, LW, 0, 0, 0, ev(3,0,1,0,0,0,0,0,0,0,0,2,0), "lw2_memrd_wait");
    step(1, LW, 0, 0, 1, ev(3,0,1,0,0,0,0,0,0,0,0,2,0), "lw2_memrd");
    step(1, LW, 0, 0, 1, ev(4,0,0,0,0,0,1,1,0,0,0,2,0), "lw2_memwb");
    // illegal opcode, sticky across addi
    step(1, BAD, 0, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "bad_fetch");
    step(1, BAD, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,0), "bad_decode");
    step(1, ADDI, 0, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,1), "addi_fetch_ill");
    step(1, ADDI, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,1), "addi_decode");
    step(1, ADDI, 0, 0, 1, ev(9,0,0,0,0,0,0,0,1,2,0,2,1), "addi_ex");
    step(1, ADDI, 0, 0, 1, ev(10,0,0,0,0,0,0,1,0,0,0,2,1), "addi_wb");
    step(1, SW, 0, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,1), "sw3_fetch_ill");
    // reset mid-store abandons the write and clears illegal_op
    step(1, SW, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0,2,1), "sw3_decode");
    step(1, SW, 0, 0, 1, ev(2,0,0,0,0,0,0,0,1,2,0,2,1), "sw3_memadr");
    step(1, SW, 0, 0, 0, ev(5,0,1,1,0,0,0,0,0,0,0,2,1), "sw3_memwr");
    step(0, SW, 0, 0, 1, ev(0,0,0,0,0,0,0,0,0,1,0,2,0), "reset_mid_instr");
    step(1, SW, 0, 0, 1, ev(0,1,0,0,1,0,0,0,0,1,0,2,0), "post_reset_fetch");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (done);
      #100000;
    join_any
    if (!done) begin
      errors++;
      $display("FAIL timeout: got no completion want completion");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
